// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Operation codes, FSM state type and helpers shared by the
//                HI/LO multiply/divide unit, E-stage control and D-stage
//                stall logic.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the four multi-cycle operations
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two multiply operations (selects the shorter busy time)
  function automatic logic is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_compute.sv
`default_nettype none
// ============================================================================
//  Module      : md_compute
//  Description : Combinational 32x32 multiply and 32/32 divide producing the
//                full HI/LO result for one mult/multu/div/divu operation.
//  Revision    : 1.0  initial release
// ============================================================================
module md_compute
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  // Operands widened to 64 bits so the low 64 product bits are exact
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_uprod = {32'h0, a} * {32'h0, b};

  // Signed divide is done on magnitudes; a divisor of zero is replaced by one
  // so the datapath never divides by zero (the result is discarded anyway).
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_nz;
  logic [31:0] w_bm_nz;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  assign w_a_mag  = a[31] ? (~a + 32'd1) : a;
  assign w_b_mag  = b[31] ? (~b + 32'd1) : b;
  assign w_b_nz   = (b == 32'h0) ? 32'd1 : b;
  assign w_bm_nz  = (b == 32'h0) ? 32'd1 : w_b_mag;
  assign w_sq_mag = w_a_mag / w_bm_nz;
  assign w_sr_mag = w_a_mag % w_bm_nz;
  assign w_uq     = a / w_b_nz;
  assign w_ur     = a % w_b_nz;

  // Select result by op; quotient sign is sign(a)^sign(b), remainder follows a
  always_comb begin
    hi_res      = 32'h0;
    lo_res      = 32'h0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT: begin
        hi_res = w_sprod[63:32];
        lo_res = w_sprod[31:0];
      end
      MD_MULTU: begin
        hi_res = w_uprod[63:32];
        lo_res = w_uprod[31:0];
      end
      MD_DIV: begin
        lo_res      = (a[31] ^ b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
        hi_res      = a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
        div_by_zero = (b == 32'h0);
      end
      MD_DIVU: begin
        lo_res      = w_uq;
        hi_res      = w_ur;
        div_by_zero = (b == 32'h0);
      end
      default: begin
        hi_res = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage HI/LO multiply/divide unit. Runs mult/multu/div/divu
//                as fixed-latency operations, handles mthi/mtlo, and serves
//                HI/LO to mfhi/mflo through md_result.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] md_result
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_hi_nxt;
  logic [31:0]        r_lo_nxt;
  logic               r_dz;

  logic [31:0]        w_hi_res;
  logic [31:0]        w_lo_res;
  logic               w_div_by_zero;
  logic               w_launch;
  logic               w_finish;

  md_compute u_compute (
    .op          (md_op),
    .a           (rs_data),
    .b           (rt_data),
    .hi_res      (w_hi_res),
    .lo_res      (w_lo_res),
    .div_by_zero (w_div_by_zero)
  );

  // New ops are only accepted while idle; anything arriving in RUN is dropped
  assign w_launch = (r_state == ST_IDLE) && start && is_muldiv(md_op);
  assign w_finish = (r_state == ST_RUN) && (r_cnt == c_CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on launch, RUN -> IDLE on the last count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_finish) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Countdown and shadow result captured at launch from the operands of that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi_nxt <= 32'h0;
      r_lo_nxt <= 32'h0;
      r_dz     <= 1'b0;
    end else if (w_launch) begin
      r_cnt    <= is_mult(md_op) ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);
      r_hi_nxt <= w_hi_res;
      r_lo_nxt <= w_lo_res;
      r_dz     <= w_div_by_zero;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  // Architectural HI/LO: committed at the end of RUN, or written by mthi/mtlo when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (w_finish) begin
      if (!r_dz) begin
        r_hi <= r_hi_nxt;
        r_lo <= r_lo_nxt;
      end
    end else if (r_state == ST_IDLE) begin
      if (md_op == MD_MTHI) r_hi <= rs_data;
      if (md_op == MD_MTLO) r_lo <= rs_data;
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // E-stage result for mfhi/mflo; zero for every other op code
  always_comb begin
    md_result = 32'h0;
    if (md_op == MD_MFHI) md_result = r_hi;
    if (md_op == MD_MFLO) md_result = r_lo;
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Scoreboard bench for mult_div_unit with an arithmetic
//                reference model and randomized operations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic        start = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] md_result;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .start     (start),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .md_result (md_result)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = 32'h0;
  logic [31:0] mdl_lo = 32'h0;
  logic [31:0] cmt_hi = 32'h0;
  logic [31:0] cmt_lo = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {HI,LO} after op, from plain 64-bit integer arithmetic
  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MD_MULT:  begin sq = sa * sb; return sq; end
      MD_MULTU: begin up = ua * ub; return up; end
      MD_DIV: begin
        if (b == 32'h0) return {hi, lo};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'h0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Monitor: pops an expectation whenever HI/LO is due to change, and checks
  // architectural stability plus md_result every cycle
  initial begin
    logic        prev_busy;
    logic        pend;
    logic [63:0] e;
    logic [31:0] exp_res;
    prev_busy = 1'b0;
    pend      = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        pend      = 1'b0;
        cmt_hi    = 32'h0;
        cmt_lo    = 32'h0;
      end else begin
        if (pend || (prev_busy && !busy)) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: hi %h lo %h with no pending op", hi_out, lo_out);
          end else begin
            e = exp_q.pop_front();
            chk("commit_hi", hi_out, e[63:32]);
            chk("commit_lo", lo_out, e[31:0]);
            cmt_hi = e[63:32];
            cmt_lo = e[31:0];
          end
        end
        chk("arch_hi", hi_out, cmt_hi);
        chk("arch_lo", lo_out, cmt_lo);
        exp_res = (md_op == MD_MFHI) ? cmt_hi : (md_op == MD_MFLO) ? cmt_lo : 32'h0;
        chk("md_result", md_result, exp_res);
        pend      = !busy && ((md_op == MD_MTHI) || (md_op == MD_MTLO));
        prev_busy = busy;
      end
    end
  end

  // Issue a mult/div op and measure how many cycles busy stays high
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          cnt;
    @(posedge clk); #1;
    md_op = op; start = 1'b1; rs_data = a; rt_data = b;
    e = ref_op(op, a, b, mdl_hi, mdl_lo);
    exp_q.push_back(e);
    {mdl_hi, mdl_lo} = e;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE; rs_data = $urandom; rt_data = $urandom;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", cnt, is_mult(op) ? MULT_N : DIV_N);
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    md_op = op; rs_data = a;
    if (op == MD_MTHI) mdl_hi = a; else mdl_lo = a;
    exp_q.push_back({mdl_hi, mdl_lo});
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  task automatic read_op(input logic [3:0] op);
    @(posedge clk); #1;
    md_op = op;
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;

    // Reset state
    repeat (2) @(posedge clk);
    #1 md_op = MD_MFHI;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_md_result", md_result, 32'h0);
    md_op = MD_NONE;
    @(negedge clk); #2 reset = 1'b1;

    // Directed cases
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi", hi_out, 32'h1);
    chk("multu_lo", lo_out, 32'hFFFF_FFFE);
    @(posedge clk); #1 md_op = MD_MFHI;
    #1 chk("mfhi_result", md_result, 32'h1);
    @(posedge clk); #1 md_op = MD_NONE;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    chk("divu_lo", lo_out, 32'h7FFF_FFFC);
    chk("divu_hi", hi_out, 32'h1);
    mt_op(MD_MTHI, 32'h1234);
    chk("mthi_hi", hi_out, 32'h1234);
    run_op(MD_DIV, 32'h5555_0001, 32'h0);
    chk("div0_hi", hi_out, 32'h1234);
    chk("div0_lo", lo_out, 32'h7FFF_FFFC);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", lo_out, 32'h8000_0000);
    chk("div_ovf_hi", hi_out, 32'h0);

    // mtlo and a second start while RUN must be ignored
    @(posedge clk); #1;
    md_op = MD_MULT; start = 1'b1; rs_data = 32'h0001_0003; rt_data = 32'hFFFF_0007;
    e = ref_op(MD_MULT, rs_data, rt_data, mdl_hi, mdl_lo);
    exp_q.push_back(e);
    {mdl_hi, mdl_lo} = e;
    @(posedge clk); #1 start = 1'b0; md_op = MD_NONE;
    @(posedge clk); #1 md_op = MD_MTLO; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1 md_op = MD_DIV; start = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1 md_op = MD_NONE; start = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("midrun_busy_cycles", cnt + 3, MULT_N);
    chk("midrun_hi", hi_out, e[63:32]);
    chk("midrun_lo", lo_out, e[31:0]);
    repeat (3) @(posedge clk);
    #1 chk("midrun_no_restart", {31'h0, busy}, 32'h0);

    // Undefined op codes: no state change, md_result zero (monitor checks)
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      md_op = 4'd9 + 4'(i); rs_data = $urandom;
    end
    @(posedge clk); #1 md_op = MD_NONE;

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0, 1: op = MD_MULT;
        2:    op = MD_MULTU;
        3, 4: op = MD_DIV;
        5:    op = MD_DIVU;
        6:    op = MD_MTHI;
        default: op = MD_MTLO;
      endcase
      if (is_muldiv(op)) run_op(op, a, b);
      else mt_op(op, a);
      if ($urandom_range(0, 3) == 0) read_op($urandom_range(0, 1) ? MD_MFHI : MD_MFLO);
    end
    mt_op(MD_MTHI, 32'hA5A5_0001);
    mt_op(MD_MTLO, 32'h5A5A_0002);

    // Asynchronous reset in the 3rd RUN cycle
    @(posedge clk); #1;
    md_op = MD_DIVU; start = 1'b1; rs_data = 32'd1000; rt_data = 32'd3;
    exp_q.push_back(ref_op(MD_DIVU, rs_data, rt_data, mdl_hi, mdl_lo));
    @(posedge clk); #1 start = 1'b0; md_op = MD_NONE;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_hi", hi_out, 32'h0);
    chk("async_rst_lo", lo_out, 32'h0);
    exp_q.delete();
    mdl_hi = 32'h0;
    mdl_lo = 32'h0;
    @(negedge clk); #2 reset = 1'b1;
    run_op(MD_MULTU, 32'd12345, 32'd678);
    chk("post_rst_lo", lo_out, 32'd8369910);
    chk("post_rst_hi", hi_out, 32'h0);

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
